// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface inst_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, we, waddr, wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, we, waddr, wdata
  );
endinterface

// File: rtl/inst_loader.sv
// Loads a length-prefixed little-endian program image from a byte stream into
// instruction memory, holding the core in reset until the image is complete.
module inst_loader #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hBFC00000,
  parameter int unsigned           MAX_WORDS  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  inst_loader_if.master     bus,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, LEN, LOAD, DONE, ERR} state_t;

  state_t                state, state_nxt;
  logic [1:0]            byte_cnt;
  logic [31:0]           len;
  logic [31:0]           word_cnt;
  logic [DATA_WIDTH-1:0] word_buf;
  logic [ADDR_WIDTH-1:0] wptr;

  logic                  accept;
  logic                  last_byte;
  logic                  last_word;
  logic [31:0]           len_full;
  logic [DATA_WIDTH-1:0] word_full;

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign len_full  = {bus.rx_data, len[31:8]};
  assign word_full = {bus.rx_data, word_buf[DATA_WIDTH-1:8]};
  assign last_word = (word_cnt + 32'd1) == len;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LEN;
      LEN: begin
        if (last_byte) begin
          if (len_full == 32'd0)           state_nxt = DONE;
          else if (len_full > MAX_WORDS)   state_nxt = ERR;
          else                             state_nxt = LOAD;
        end
      end
      // word_cnt already counts the word being written during the we cycle
      LOAD: if (bus.we && (word_cnt == len)) state_nxt = DONE;
      DONE: if (start) state_nxt = LEN;
      ERR:  if (start) state_nxt = LEN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rx_ready <= 1'b0;
      bus.we       <= 1'b0;
      bus.waddr    <= BASE_ADDR;
      bus.wdata    <= '0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      byte_cnt     <= '0;
      word_cnt     <= '0;
      len          <= '0;
      word_buf     <= '0;
      wptr         <= BASE_ADDR;
    end else begin
      bus.we       <= 1'b0;
      // Drop ready together with the final write so no byte is taken past the image.
      bus.rx_ready <= ((state_nxt == LEN) || (state_nxt == LOAD)) &&
                      !((state == LOAD) && last_byte && last_word);
      done         <= (state_nxt == DONE);
      cpu_rst      <= (state_nxt != DONE);
      err          <= (state_nxt == ERR);

      if ((state == IDLE) || ((state_nxt == LEN) && (state != LEN))) begin
        byte_cnt <= '0;
        word_cnt <= '0;
        wptr     <= BASE_ADDR;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == LEN) begin
          len <= len_full;
        end else begin
          word_buf <= word_full;
          if (byte_cnt == 2'd3) begin
            bus.we    <= 1'b1;
            bus.wdata <= word_full;
            bus.waddr <= wptr;
            wptr      <= wptr + ADDR_WIDTH'(4);
            word_cnt  <= word_cnt + 32'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: normal, gapped, oversize, empty, reset-abort
// and full-capacity program loads.
module tb_inst_loader;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_rst, done, err;

  int tests  = 0;
  int failed = 0;
  int we_count = 0;

  inst_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  inst_loader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .BASE_ADDR (32'hBFC00000),
    .MAX_WORDS (1024)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bus    (bus),
    .cpu_rst(cpu_rst),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.we === 1'b1) we_count++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rx_ready_wait", {63'd0, bus.rx_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax);
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
  endtask

  task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, "_we"},    {63'd0, bus.we}, 64'd1);
    chk({tag, "_waddr"}, {32'd0, bus.waddr}, {32'd0, addr});
    chk({tag, "_wdata"}, {32'd0, bus.wdata}, {32'd0, data});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_rx_ready", {63'd0, bus.rx_ready}, 64'd1);
    chk("start_done_low", {63'd0, done}, 64'd0);
    chk("start_err_low",  {63'd0, err},  64'd0);
    chk("start_cpu_rst",  {63'd0, cpu_rst}, 64'd1);
  endtask

  initial begin
    int base_cnt;
    int bad;
    logic [31:0] w;

    rst = 1'b1;
    start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_cpu_rst",  {63'd0, cpu_rst}, 64'd1);
    chk("rst_rx_ready", {63'd0, bus.rx_ready}, 64'd0);
    chk("rst_we",       {63'd0, bus.we}, 64'd0);
    chk("rst_done",     {63'd0, done}, 64'd0);
    chk("rst_err",      {63'd0, err}, 64'd0);
    chk("rst_waddr",    {32'd0, bus.waddr}, 64'hBFC00000);
    chk("rst_wdata",    {32'd0, bus.wdata}, 64'd0);
    bus.rx_valid = 1'b1;
    repeat (6) @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("idle_rx_ready", {63'd0, bus.rx_ready}, 64'd0);
    chk("idle_we_count", we_count, 64'd0);
    chk("idle_cpu_rst",  {63'd0, cpu_rst}, 64'd1);

    // N=2, no gaps
    pulse_start();
    send_word(32'h0000_0002, 0);
    chk("len2_rx_ready", {63'd0, bus.rx_ready}, 64'd1);
    send_word(32'h0050_0513, 0);
    expect_write("n2_w0", 32'hBFC00000, 32'h00500513);
    send_word(32'h0000_006F, 0);
    expect_write("n2_w1", 32'hBFC00004, 32'h0000006F);
    chk("n2_last_rx_ready", {63'd0, bus.rx_ready}, 64'd0);
    @(negedge clk);
    chk("n2_we_low",   {63'd0, bus.we}, 64'd0);
    chk("n2_done",     {63'd0, done}, 64'd1);
    chk("n2_cpu_rst",  {63'd0, cpu_rst}, 64'd0);
    repeat (3) @(negedge clk);
    chk("n2_we_count", we_count, 64'd2);
    chk("n2_done_hold", {63'd0, done}, 64'd1);

    // same frame with random valid gaps
    base_cnt = we_count;
    pulse_start();
    chk("restart_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    send_word(32'h0000_0002, 5);
    send_word(32'h0050_0513, 5);
    expect_write("gap_w0", 32'hBFC00000, 32'h00500513);
    send_word(32'h0000_006F, 5);
    expect_write("gap_w1", 32'hBFC00004, 32'h0000006F);
    repeat (3) @(negedge clk);
    chk("gap_done",     {63'd0, done}, 64'd1);
    chk("gap_we_count", we_count - base_cnt, 64'd2);

    // N=1025 -> ERR
    base_cnt = we_count;
    pulse_start();
    send_word(32'h0000_0401, 0);
    chk("err_flag",     {63'd0, err}, 64'd1);
    chk("err_rx_ready", {63'd0, bus.rx_ready}, 64'd0);
    chk("err_cpu_rst",  {63'd0, cpu_rst}, 64'd1);
    chk("err_done",     {63'd0, done}, 64'd0);
    bus.rx_valid = 1'b1;
    repeat (8) @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("err_we_count", we_count - base_cnt, 64'd0);
    chk("err_hold",     {63'd0, err}, 64'd1);
    pulse_start();
    chk("err_cleared",  {63'd0, err}, 64'd0);
    send_word(32'h0000_0001, 0);
    send_word(32'hDDCC_BBAA, 0);
    expect_write("after_err", 32'hBFC00000, 32'hDDCCBBAA);
    @(negedge clk);
    chk("after_err_done", {63'd0, done}, 64'd1);

    // N=0 -> DONE directly
    base_cnt = we_count;
    pulse_start();
    send_word(32'h0000_0000, 0);
    chk("n0_done",     {63'd0, done}, 64'd1);
    chk("n0_cpu_rst",  {63'd0, cpu_rst}, 64'd0);
    chk("n0_rx_ready", {63'd0, bus.rx_ready}, 64'd0);
    repeat (3) @(negedge clk);
    chk("n0_we_count", we_count - base_cnt, 64'd0);

    // reset in the middle of word 1
    base_cnt = we_count;
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_word(32'h1234_5678, 0);
    expect_write("abort_w0", 32'hBFC00000, 32'h12345678);
    send_byte(8'h9A, 0);
    send_byte(8'hBC, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_cpu_rst",  {63'd0, cpu_rst}, 64'd1);
    chk("abort_rx_ready", {63'd0, bus.rx_ready}, 64'd0);
    chk("abort_we",       {63'd0, bus.we}, 64'd0);
    chk("abort_done",     {63'd0, done}, 64'd0);
    repeat (4) @(negedge clk);
    chk("abort_we_count", we_count - base_cnt, 64'd1);
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_word(32'h1122_3344, 0);
    expect_write("reload_w0", 32'hBFC00000, 32'h11223344);
    send_word(32'h5566_7788, 0);
    expect_write("reload_w1", 32'hBFC00004, 32'h55667788);
    @(negedge clk);
    chk("reload_done",    {63'd0, done}, 64'd1);
    chk("reload_cpu_rst", {63'd0, cpu_rst}, 64'd0);

    // N == MAX_WORDS, with start pulsed mid-load (ignored)
    base_cnt = we_count;
    bad = 0;
    pulse_start();
    send_word(32'd1024, 0);
    for (int i = 0; i < 1023; i++) begin
      w = 32'hA5A5_0000 ^ i;
      if (i == 500) start = 1'b1;
      send_word(w, 0);
      start = 1'b0;
      if (bus.we !== 1'b1 || bus.waddr !== 32'hBFC00000 + 32'(4 * i) || bus.wdata !== w)
        bad++;
    end
    chk("max_stream_writes", bad, 64'd0);
    chk("max_not_done_yet",  {63'd0, done}, 64'd0);
    send_word(32'hA5A5_0000 ^ 32'd1023, 0);
    expect_write("max_last", 32'hBFC00FFC, 32'hA5A503FF);
    chk("max_last_rx_ready", {63'd0, bus.rx_ready}, 64'd0);
    @(negedge clk);
    chk("max_done",     {63'd0, done}, 64'd1);
    chk("max_err",      {63'd0, err},  64'd0);
    chk("max_we_count", we_count - base_cnt, 64'd1024);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer side of the instruction memory: fills it with a program from a byte stream before the core runs.
- Frame format: a 4-byte little-endian word count N, then N instruction words, each sent as 4 bytes, little-endian.
- Bytes are assembled into 32-bit words and written sequentially from BASE_ADDR.
- Holds the core in reset until the load completes.

Parameters:
- DATA_WIDTH, 32, instruction word width; fixed at 32.
- ADDR_WIDTH, 32, width of the byte address driven to instruction memory.
- BASE_ADDR, 32'hBFC00000, byte address of the first instruction written.
- MAX_WORDS, 1024, instruction memory capacity in words.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a load; honoured only in IDLE, DONE or ERR.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- we  output  1  instruction memory write enable; one-cycle pulse per word.
- waddr  output  ADDR_WIDTH  write byte address.
- wdata  output  DATA_WIDTH  write data.
- cpu_rst  output  1  core reset; high except in DONE.
- done  output  1  load completed successfully.
- err  output  1  word count exceeded MAX_WORDS.

Behaviour:
- Reset values:
  - state=IDLE, rx_ready=0, we=0, waddr=BASE_ADDR, wdata=0, cpu_rst=1, done=0, err=0.
  - Byte counter and word counter cleared.
- Handshake: a byte is accepted on a rising edge where rx_valid && rx_ready. rx_ready is a registered function of state: 1 only in LEN and LOAD.
- IDLE: start -> LEN next cycle. Byte and word counters cleared.
- LEN:
  - Accepted bytes shift into the count register, little-endian; byte 0 is the LSB.
  - After the 4th accepted byte:
    - N==0 -> DONE.
    - N>MAX_WORDS -> ERR.
    - Otherwise -> LOAD.
- LOAD:
  - Bytes assemble into a word buffer; byte k of the word goes to bits [8k+7:8k].
  - On acceptance of the 4th byte, in the following cycle: we=1, wdata=assembled word, waddr=BASE_ADDR+4*word_index. The write latency is one cycle after the last byte handshake.
  - rx_ready remains 1 during the write pulse. The next word's first byte may be accepted in the same cycle as we.
  - The word index increments after each write.
  - After the write of word N-1 -> DONE. rx_ready drops to 0 in the same cycle that last write is issued.
- DONE: done=1, cpu_rst=0, rx_ready=0. Stays in DONE until start or rst. start -> LEN with done=0, cpu_rst=1.
- ERR: err=1, cpu_rst=1, rx_ready=0, no writes. start -> LEN with err=0.
- start while in LEN or LOAD: ignored.
- rx_valid gaps, any length, are allowed mid-word; partial-word state is held.
- rst mid-load:
  - Immediate return to IDLE.
  - Any pending partial word is discarded; no we pulse.
  - cpu_rst=1.
  - Memory contents already written are not reverted.
- Address arithmetic is modulo 2^ADDR_WIDTH, with no wrap check beyond MAX_WORDS.
- we never asserts outside LOAD. At most one we per 4 accepted payload bytes.
- N==MAX_WORDS is legal. The last write goes to BASE_ADDR+4*(MAX_WORDS-1).

Test Plan:
- Reset then idle -> cpu_rst=1, rx_ready=0, we never pulses, done=0, err=0.
- Load N=2 with bytes 02 00 00 00 | 13 05 50 00 | 6F 00 00 00, rx_valid held high:
  - we pulses with (BFC00000, 00500513) then (BFC00004, 0000006F).
  - Each pulse falls one cycle after the 4th byte of its word.
  - Then done=1, cpu_rst=0.
- Same frame with random 0-5 cycle rx_valid gaps -> identical writes and addresses, no extra we pulses.
- Length 01 04 00 00 (N=1025 > MAX_WORDS) -> ERR: err=1, rx_ready=0, no we pulses. Then start -> err=0, LEN, accepts a new frame.
- N=0 frame (00 00 00 00) -> DONE directly after the 4th byte, no we pulses, cpu_rst=0.
- rst asserted after 2 payload bytes of word 1 -> IDLE next cycle, no we pulse for the partial word, cpu_rst=1. A fresh start plus a full frame then loads correctly.
